// File: rtl/sprite_arb_pkg.sv
// Shared sizes and the read-data owner tag for the sprite RAM arbiter.
package sprite_arb_pkg;

   localparam int AW = 8;
   localparam int DW = 16;

   // Who receives mem_readdata on the cycle after a read grant.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

endpackage

// File: rtl/sprite_arb_starve_ctr.sv
// Counts display grants taken while a host command waits; saturates at the limit.
module sprite_arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic host_pend,
   input  logic host_gnt,
   input  logic disp_gnt,
   output logic at_limit
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   // Clear whenever the host is served or stops asking; otherwise count display wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (host_gnt || !host_pend) begin
         starve_cnt <= '0;
      end else if (disp_gnt && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign at_limit = (starve_cnt == LIMIT);

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Single-port sprite RAM shared by the display engine (priority) and an
// Avalon-MM host. One access per cycle; read data returns one cycle later and
// is steered by a registered owner tag.
module sprite_mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = sprite_arb_pkg::AW,
   parameter int DW           = sprite_arb_pkg::DW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              disp_req,
   input  logic [AW-1:0]     disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DW-1:0]     disp_rdata,
   input  logic              host_read,
   input  logic              host_write,
   input  logic [AW-1:0]     host_address,
   input  logic [DW/8-1:0]   host_byteenable,
   input  logic [DW-1:0]     host_writedata,
   output logic              host_waitrequest,
   output logic              host_readdatavalid,
   output logic [DW-1:0]     host_readdata,
   output logic [AW-1:0]     mem_address,
   output logic [DW/8-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DW-1:0]     mem_writedata,
   output logic              mem_clken,
   input  logic [DW-1:0]     mem_readdata
);

   import sprite_arb_pkg::owner_t;
   import sprite_arb_pkg::OWN_NONE;
   import sprite_arb_pkg::OWN_DISP;
   import sprite_arb_pkg::OWN_HOST;

   logic   host_pend;
   logic   host_gnt;
   logic   at_limit;
   logic   any_gnt;
   owner_t owner_q;

   assign host_pend = host_read | host_write;

   // Reset gates the grants directly so nothing reaches the RAM while held.
   assign host_gnt = reset_n & host_pend & (~disp_req | at_limit);
   assign disp_gnt = reset_n & disp_req & ~host_gnt;
   assign any_gnt  = host_gnt | disp_gnt;

   assign host_waitrequest = host_pend & ~host_gnt;

   sprite_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (clk),
      .reset_n   (reset_n),
      .host_pend (host_pend),
      .host_gnt  (host_gnt),
      .disp_gnt  (disp_gnt),
      .at_limit  (at_limit)
   );

   // RAM command from the winner; everything idles to zero without a grant.
   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_write      = 1'b0;
      mem_chipselect = any_gnt;
      mem_clken      = any_gnt;
      if (host_gnt) begin
         mem_address    = host_address;
         mem_byteenable = host_byteenable;
         mem_write      = host_write;
         mem_writedata  = host_write ? host_writedata : '0;
      end else if (disp_gnt) begin
         mem_address    = disp_addr;
         mem_byteenable = '1;
      end
   end

   // Remember who owns next cycle's q; a read+write host command is a write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q <= OWN_NONE;
      end else if (disp_gnt) begin
         owner_q <= OWN_DISP;
      end else if (host_gnt && !host_write) begin
         owner_q <= OWN_HOST;
      end else begin
         owner_q <= OWN_NONE;
      end
   end

   assign disp_rvalid        = (owner_q == OWN_DISP);
   assign host_readdatavalid = (owner_q == OWN_HOST);
   assign disp_rdata         = disp_rvalid ? mem_readdata : '0;
   assign host_readdata      = host_readdatavalid ? mem_readdata : '0;

endmodule
